// File: rtl/route_table_sched.sv
// Arbitrates two writers and a bulk-clear engine onto the single LPM table write port.
// Every strobe lasts one cycle and is followed by GAP_CYCLES idle cycles; malformed entries are rejected.
module route_table_sched #(
  parameter int TABLE_SIZE = 1024,
  parameter int ADDR_W     = 10,
  parameter int GAP_CYCLES = 1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [98:0]       req0_entry,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [98:0]       req1_entry,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              table_write_enable,
  output logic [ADDR_W-1:0] table_write_addr,
  output logic              table_entry_valid,
  output logic [31:0]       table_entry_prefix,
  output logic [5:0]        table_entry_prefix_len,
  output logic [2:0]        table_entry_action,
  output logic [47:0]       table_entry_dst_mac,
  output logic [8:0]        table_entry_egress_port,
  output logic              req_err,
  output logic [31:0]       wr_count,
  output logic [31:0]       rej_count,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_GAP       = 3'd2,
    S_CLEAR_WR  = 3'd3,
    S_CLEAR_GAP = 3'd4
  } state_t;

  localparam logic [15:0]       GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(TABLE_SIZE - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_rr_ptr;
  logic                r_clr_pend;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic [15:0]         r_gap_cnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [98:0]         r_entry;
  logic                r_req_err;
  logic                r_clr_busy;
  logic                r_clr_done;
  logic [31:0]         r_wr_count;
  logic [31:0]         r_rej_count;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_accept;
  logic                w_clr_go;
  logic                w_clr_next;
  logic                w_clr_fin;
  logic                w_gap_done;
  logic                w_bad0;
  logic                w_bad1;
  logic                w_sel_bad;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [98:0]         w_sel_entry;
  logic                w_wr_inc;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [98:0]         w_wr_entry;

  // Entry layout: [98]valid [97:66]prefix [65:60]prefix_len [59:57]action [56:9]dst_mac [8:0]port
  function automatic logic entry_bad(input logic [98:0] e);
    return (e[65:60] > 6'd32) || (e[98] && (e[59:57] > 3'd3));
  endfunction

  assign w_bad0      = entry_bad(req0_entry);
  assign w_bad1      = entry_bad(req1_entry);
  assign w_accept    = w_gnt0 || w_gnt1;
  assign w_sel_bad   = w_gnt1 ? w_bad1 : w_bad0;
  assign w_sel_addr  = w_gnt1 ? req1_addr : req0_addr;
  assign w_sel_entry = w_gnt1 ? req1_entry : req0_entry;
  assign w_gap_done  = (r_gap_cnt == GAP_LAST);

  // Handshake: a request transfers on a rising aclk edge where valid && ready.
  // Ready is only ever raised in IDLE, towards at most one requester, and the
  // requester must hold valid/addr/entry stable until that transfer.
  always_comb begin
    w_next_state = r_state;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_clr_go     = 1'b0;
    w_clr_next   = 1'b0;
    w_clr_fin    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_clr_pend || clr_start) begin
          w_clr_go     = 1'b1;
          w_next_state = S_CLEAR_WR;
        end else if (req0_valid && (!req1_valid || r_rr_ptr)) begin
          w_gnt0       = 1'b1;
          w_next_state = w_bad0 ? S_GAP : S_WRITE;
        end else if (req1_valid) begin
          w_gnt1       = 1'b1;
          w_next_state = w_bad1 ? S_GAP : S_WRITE;
        end
      end
      S_WRITE:    w_next_state = S_GAP;
      S_GAP:      if (w_gap_done) w_next_state = S_IDLE;
      S_CLEAR_WR: w_next_state = S_CLEAR_GAP;
      S_CLEAR_GAP: begin
        if (w_gap_done) begin
          if (r_clr_addr == CLR_LAST) begin
            w_clr_fin    = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_clr_next   = 1'b1;
            w_next_state = S_CLEAR_WR;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_inc   = 1'b0;
    w_wr_addr  = '0;
    w_wr_entry = '0;
    if (w_clr_go) begin
      w_wr_inc = 1'b1;
    end else if (w_clr_next) begin
      w_wr_inc  = 1'b1;
      w_wr_addr = r_clr_addr + 1'b1;
    end else if (w_accept && !w_sel_bad) begin
      w_wr_inc   = 1'b1;
      w_wr_addr  = w_sel_addr;
      w_wr_entry = w_sel_entry;
    end
  end

  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Strobe, address and fields are reloaded every cycle so they fall back to 0 after a strobe.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_rr_ptr    <= 1'b1;
      r_clr_pend  <= 1'b0;
      r_clr_addr  <= '0;
      r_gap_cnt   <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_entry     <= '0;
      r_req_err   <= 1'b0;
      r_clr_busy  <= 1'b0;
      r_clr_done  <= 1'b0;
      r_wr_count  <= '0;
      r_rej_count <= '0;
    end else begin
      r_we       <= w_wr_inc;
      r_addr     <= w_wr_addr;
      r_entry    <= w_wr_entry;
      r_req_err  <= w_accept && w_sel_bad;
      r_clr_done <= w_clr_fin;

      if (r_state == S_GAP || r_state == S_CLEAR_GAP) r_gap_cnt <= r_gap_cnt + 16'd1;
      else                                            r_gap_cnt <= '0;

      if (w_accept) r_rr_ptr <= w_gnt1;

      if (w_clr_go)                        r_clr_pend <= 1'b0;
      else if (clr_start && r_state != S_IDLE) r_clr_pend <= 1'b1;

      if (w_clr_go)        r_clr_addr <= '0;
      else if (w_clr_next) r_clr_addr <= r_clr_addr + 1'b1;

      if (w_clr_go)       r_clr_busy <= 1'b1;
      else if (w_clr_fin) r_clr_busy <= 1'b0;

      if (w_wr_inc && r_wr_count != 32'hFFFF_FFFF) r_wr_count <= r_wr_count + 32'd1;
      if (w_accept && w_sel_bad && r_rej_count != 32'hFFFF_FFFF) r_rej_count <= r_rej_count + 32'd1;
    end
  end

  // Ready must stay low while reset is held even though the FSM already reads IDLE.
  assign req0_ready              = w_gnt0 && !aresetn;
  assign req1_ready              = w_gnt1 && !aresetn;
  assign clr_busy                = r_clr_busy;
  assign clr_done                = r_clr_done;
  assign table_write_enable      = r_we;
  assign table_write_addr        = r_addr;
  assign table_entry_valid       = r_entry[98];
  assign table_entry_prefix      = r_entry[97:66];
  assign table_entry_prefix_len  = r_entry[65:60];
  assign table_entry_action      = r_entry[59:57];
  assign table_entry_dst_mac     = r_entry[56:9];
  assign table_entry_egress_port = r_entry[8:0];
  assign req_err                 = r_req_err;
  assign wr_count                = r_wr_count;
  assign rej_count               = r_rej_count;
  assign o_dbg_state             = r_state;

endmodule

// File: tb/tb_route_table_sched.sv
// Randomized and directed bench for route_table_sched: drivers feed request queues,
// a negedge monitor predicts table writes/rejects from the entry rules and scoreboards them.
`timescale 1ns/1ps
module tb_route_table_sched;
  localparam int TABLE_SIZE = 1024;
  localparam int ADDR_W     = 10;
  localparam int GAP        = 1;
  localparam int EW         = 1 + 32 + ADDR_W + 99;

  typedef struct packed {
    logic              chk;
    logic [31:0]       cyc;
    logic [ADDR_W-1:0] addr;
    logic [98:0]       entry;
  } exp_t;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b1;
  logic              req0_valid, req1_valid, req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [98:0]       req0_entry, req1_entry;
  logic              clr_start = 1'b0;
  logic              clr_busy, clr_done, table_write_enable, table_entry_valid, req_err;
  logic [ADDR_W-1:0] table_write_addr;
  logic [31:0]       table_entry_prefix, wr_count, rej_count;
  logic [5:0]        table_entry_prefix_len;
  logic [2:0]        table_entry_action, dbg_state;
  logic [47:0]       table_entry_dst_mac;
  logic [8:0]        table_entry_egress_port;

  route_table_sched #(.TABLE_SIZE(TABLE_SIZE), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_entry(req0_entry),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_entry(req1_entry),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .table_write_enable(table_write_enable), .table_write_addr(table_write_addr),
    .table_entry_valid(table_entry_valid), .table_entry_prefix(table_entry_prefix),
    .table_entry_prefix_len(table_entry_prefix_len), .table_entry_action(table_entry_action),
    .table_entry_dst_mac(table_entry_dst_mac), .table_entry_egress_port(table_entry_egress_port),
    .req_err(req_err), .wr_count(wr_count), .rej_count(rej_count), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  // ---------------- bench state ----------------
  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  logic [EW-1:0]          exp_q[$];
  int                     rej_q[$];
  logic [ADDR_W+98:0]     q0[$], q1[$];
  int acc_cyc_q[$], acc_who_q[$];
  int wr_model, rej_model, last_gnt, next_ok, exp_done_cyc, last_done_cyc;
  int done_cnt, last_strobe_cyc, strobe_cnt = 0, hs_cnt = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [98:0] mk(input bit v, input logic [31:0] p, input int len,
                                     input int act, input logic [47:0] mac, input int port);
    return {v, p, 6'(len), 3'(act), mac, 9'(port)};
  endfunction

  // Entry rules: prefix length over 32 is malformed; a valid route may only use actions 0..3.
  function automatic bit is_bad(input logic [98:0] e);
    int len, act;
    len = int'(e[65:60]);
    act = int'(e[59:57]);
    return (len > 32) || (e[98] && act > 3);
  endfunction

  function automatic logic [191:0] out_vec();
    return {req0_ready, req1_ready, clr_busy, clr_done, table_write_enable, table_write_addr,
            table_entry_valid, table_entry_prefix, table_entry_prefix_len, table_entry_action,
            table_entry_dst_mac, table_entry_egress_port, req_err, wr_count, rej_count};
  endfunction

  task automatic model_reset();
    exp_q.delete(); rej_q.delete(); acc_cyc_q.delete(); acc_who_q.delete();
    wr_model = 0; rej_model = 0; last_gnt = 1; next_ok = 0;
    exp_done_cyc = -1; last_done_cyc = -1; done_cnt = 0; last_strobe_cyc = -100;
  endtask

  task automatic push_clear();
    exp_t x;
    for (int a = 0; a < TABLE_SIZE; a++) begin
      x.chk = 1'b0; x.cyc = '0; x.addr = ADDR_W'(a); x.entry = '0;
      exp_q.push_back(x);
    end
    wr_model += TABLE_SIZE;
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b1;
    model_reset();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid ||
            exp_q.size() > 0 || rej_q.size() > 0) && n < budget) begin
      @(posedge aclk);
      n++;
    end
    check({name, "_drain_timeout"}, n >= budget, 0);
    repeat (4) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_start = 1'b1;
    @(posedge aclk); #1;
    clr_start = 1'b0;
  endtask

  // ---------------- driver tasks (one per requester) ----------------
  initial begin : drv0
    logic hs;
    req0_valid = 1'b0; req0_addr = '0; req0_entry = '0;
    forever begin
      @(negedge aclk);
      hs = req0_valid && req0_ready && !aresetn;
      @(posedge aclk); #1;
      if (hs) req0_valid = 1'b0;
      if (!req0_valid && q0.size() > 0) begin
        {req0_addr, req0_entry} = q0.pop_front();
        req0_valid = 1'b1;
      end
    end
  end

  initial begin : drv1
    logic hs;
    req1_valid = 1'b0; req1_addr = '0; req1_entry = '0;
    forever begin
      @(negedge aclk);
      hs = req1_valid && req1_ready && !aresetn;
      @(posedge aclk); #1;
      if (hs) req1_valid = 1'b0;
      if (!req1_valid && q1.size() > 0) begin
        {req1_addr, req1_entry} = q1.pop_front();
        req1_valid = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge aclk) begin
    exp_t x;
    logic [98:0] e;
    logic [ADDR_W-1:0] a;
    int g, exp_g;
    bit h0, h1;
    if (!aresetn) begin
      cyc++;
      if (table_write_enable) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", table_write_enable, 0);
        end else begin
          x = exp_q.pop_front();
          check("strobe_addr", table_write_addr, x.addr);
          check("strobe_entry", {table_entry_valid, table_entry_prefix, table_entry_prefix_len,
                                 table_entry_action, table_entry_dst_mac, table_entry_egress_port}, x.entry);
          if (x.chk) check("strobe_latency", cyc, x.cyc);
          else if (x.addr != 0) check("clear_spacing", cyc - last_strobe_cyc, 1 + GAP);
          if (!x.chk && int'(x.addr) == TABLE_SIZE - 1) exp_done_cyc = cyc + 1 + GAP;
        end
        last_strobe_cyc = cyc;
      end else if (cyc == last_strobe_cyc + 1) begin
        check("fields_zero_after_strobe", {table_write_addr, table_entry_valid, table_entry_prefix,
              table_entry_prefix_len, table_entry_action, table_entry_dst_mac, table_entry_egress_port}, 0);
      end
      if (req_err) begin
        if (rej_q.size() == 0) check("unexpected_req_err", req_err, 0);
        else check("req_err_cycle", cyc, rej_q.pop_front());
      end
      if (clr_done) begin
        done_cnt++;
        check("clr_done_cycle", cyc, exp_done_cyc);
        last_done_cyc = cyc;
      end
      if (clr_busy && (req0_valid || req1_valid))
        check("ready_during_clear", {req0_ready, req1_ready}, 0);
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      if (h0 || h1) begin
        check("single_grant", h0 && h1, 0);
        if (req0_valid && req1_valid) exp_g = (last_gnt == 1) ? 0 : 1;
        else                          exp_g = req0_valid ? 0 : 1;
        g = h1 ? 1 : 0;
        check("rr_grant", g, exp_g);
        check("accept_spacing", cyc >= next_ok, 1);
        last_gnt = g;
        a = h1 ? req1_addr : req0_addr;
        e = h1 ? req1_entry : req0_entry;
        if (is_bad(e)) begin
          rej_q.push_back(cyc + 1);
          rej_model++;
          next_ok = cyc + 1 + GAP;
        end else begin
          x.chk = 1'b1; x.cyc = 32'(cyc + 1); x.addr = a; x.entry = e;
          exp_q.push_back(x);
          wr_model++;
          next_ok = cyc + 2 + GAP;
        end
        acc_cyc_q.push_back(cyc);
        acc_who_q.push_back(g);
        hs_cnt++;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int n, h, base, snap;
    int pat[4];
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    check("reset_outputs", out_vec(), 0);
    check("reset_state", dbg_state, 0);
    aresetn = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // T1: single good write
    q0.push_back({10'd0, mk(1, 32'hC0A8_0100, 24, 1, 48'h0011_2233_4455, 1)});
    drain(200, "t1");
    check("t1_wr_count", wr_count, 1);

    // T2: both requesters contend for four writes
    do_reset();
    @(posedge aclk);
    q0.push_back({10'd10, mk(1, 32'h0A00_0000, 8, 0, 48'hAAAA_0000_0001, 2)});
    q0.push_back({10'd12, mk(1, 32'h0A01_0000, 16, 2, 48'hAAAA_0000_0003, 4)});
    q1.push_back({10'd11, mk(1, 32'h0B00_0000, 8, 3, 48'hBBBB_0000_0002, 3)});
    q1.push_back({10'd13, mk(0, 32'h0B01_0000, 16, 7, 48'hBBBB_0000_0004, 5)});
    drain(200, "t2");
    pat = '{0, 1, 0, 1};
    check("t2_accept_count", acc_who_q.size(), 4);
    if (acc_who_q.size() == 4) begin
      for (int i = 0; i < 4; i++) check("t2_grant_order", acc_who_q[i], pat[i]);
      for (int i = 1; i < 4; i++) check("t2_accept_spacing", acc_cyc_q[i] - acc_cyc_q[i-1], 2 + GAP);
    end
    check("t2_wr_count", wr_count, 4);

    // T3: malformed entry from req1, then req0 served
    base = acc_who_q.size();
    @(posedge aclk);
    q1.push_back({10'd20, mk(1, 32'h0C00_0000, 40, 1, 48'h1, 6)});
    @(posedge aclk);
    q0.push_back({10'd21, mk(1, 32'h0D00_0000, 32, 3, 48'h2, 7)});
    drain(200, "t3");
    check("t3_rej_count", rej_count, 1);
    check("t3_wr_count", wr_count, 5);
    check("t3_accept_count", acc_who_q.size(), base + 2);
    if (acc_who_q.size() == base + 2) begin
      check("t3_first_req1", acc_who_q[base], 1);
      check("t3_then_req0", acc_who_q[base + 1], 0);
    end

    // T4: clear requested twice during a write collapses into one clear
    do_reset();
    h = hs_cnt;
    q0.push_back({10'd33, mk(1, 32'h1400_0000, 12, 2, 48'hCAFE_F00D_0001, 9)});
    n = 0;
    while (hs_cnt == h && n < 50) begin @(posedge aclk); n++; end
    check("t4_accept_timeout", n >= 50, 0);
    #1 clr_start = 1'b1;
    repeat (2) @(posedge aclk);
    #1 clr_start = 1'b0;
    push_clear();
    drain(2 * TABLE_SIZE * (1 + GAP) + 100, "t4");
    check("t4_wr_count", wr_count, 1025);
    check("t4_done_count", done_cnt, 1);
    check("t4_busy_after", clr_busy, 0);

    // T5: reset in the middle of a clear
    push_clear();
    pulse_clr();
    n = 0;
    while (!(table_write_enable && table_write_addr == 10'd500) && n < 2000) begin
      @(negedge aclk); n++;
    end
    check("t5_reach_500", n >= 2000, 0);
    aresetn = 1'b1;
    #1;
    check("t5_reset_outputs", out_vec(), 0);
    check("t5_reset_state", dbg_state, 0);
    model_reset();
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b0;
    snap = strobe_cnt;
    repeat (30) @(posedge aclk);
    #1;
    check("t5_no_strobes", strobe_cnt - snap, 0);
    check("t5_idle", {dbg_state, clr_busy, wr_count}, 0);

    // T6: clear and request in the same IDLE cycle
    @(posedge aclk);
    push_clear();
    q0.push_back({10'd77, mk(1, 32'hAC10_0000, 20, 0, 48'h0102_0304_0506, 11)});
    #1 clr_start = 1'b1;
    @(posedge aclk);
    #1 clr_start = 1'b0;
    drain(2 * TABLE_SIZE * (1 + GAP) + 100, "t6");
    check("t6_done_count", done_cnt, 1);
    check("t6_wr_count", wr_count, 1025);
    check("t6_accept_count", acc_cyc_q.size(), 1);
    if (acc_cyc_q.size() == 1) check("t6_req_after_done", acc_cyc_q[0] >= last_done_cyc, 1);

    // Random mix of good and malformed requests on both ports
    for (int i = 0; i < 60; i++) begin
      logic [ADDR_W+98:0] r;
      r = {ADDR_W'($urandom_range(0, TABLE_SIZE - 1)),
           mk(bit'($urandom_range(0, 1)), $urandom, $urandom_range(0, 40), $urandom_range(0, 7),
              48'({$urandom, $urandom}), $urandom_range(0, 511))};
      if ($urandom_range(0, 1) == 0) q0.push_back(r);
      else                           q1.push_back(r);
      repeat ($urandom_range(0, 3)) @(posedge aclk);
    end
    drain(2000, "rand");
    check("rand_wr_count", wr_count, wr_model);
    check("rand_rej_count", rej_count, rej_model);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
